// File: rtl/wb_fir_stream_dma.sv
// Wishbone initiator that moves a block of samples through the FIR stream ports:
// read X from memory, push it to stream-in, pull Y from stream-out, store Y.
module wb_fir_stream_dma #(
    parameter logic [31:0] FIR_BASE = 32'h3000_0000,
    parameter int          TIMEOUT  = 1024
) (
    input  logic        axis_clk,
    input  logic        axis_rst_n,
    input  logic        start,
    input  logic [31:0] src_base,
    input  logic [31:0] dst_base,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] sample_cnt,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [2:0]  dbg_state
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] FIR_IN  = FIR_BASE + 32'h40;
    localparam logic [31:0] FIR_OUT = FIR_BASE + 32'h44;

    typedef enum logic [2:0] {IDLE, RD_X, WR_X, RD_Y, WR_Y, GAP, DONE} state_t;

    state_t        state, after_gap;
    logic [31:0]   src_r, dst_r, x_reg, y_reg;
    logic [15:0]   len_r, idx;
    logic [TW-1:0] to_cnt;
    logic [15:0]   idx_next;

    assign idx_next  = idx + 16'd1;
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
    assign dbg_state = state;

    // Handshake: a transfer completes on the edge where cyc and ack are both high;
    // adr/we/dat are held constant while cyc is high and cyc drops after every ack.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state      <= IDLE;
            after_gap  <= IDLE;
            src_r      <= '0;
            dst_r      <= '0;
            len_r      <= '0;
            idx        <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            to_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sample_cnt <= '0;
            wbm_cyc_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            src_r      <= src_base;
                            dst_r      <= dst_base;
                            len_r      <= len;
                            idx        <= '0;
                            sample_cnt <= '0;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            to_cnt     <= '0;
                            wbm_cyc_o  <= 1'b1;
                            wbm_we_o   <= 1'b0;
                            wbm_adr_o  <= src_base;
                            wbm_dat_o  <= '0;
                            state      <= RD_X;
                        end
                    end
                end
                RD_X, WR_X, RD_Y, WR_Y: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        to_cnt    <= '0;
                        state     <= GAP;
                        // Next transfer's address/data are staged while cyc is low.
                        case (state)
                            RD_X: begin
                                x_reg     <= wbm_dat_i;
                                wbm_we_o  <= 1'b1;
                                wbm_adr_o <= FIR_IN;
                                wbm_dat_o <= wbm_dat_i;
                                after_gap <= WR_X;
                            end
                            WR_X: begin
                                wbm_we_o  <= 1'b0;
                                wbm_adr_o <= FIR_OUT;
                                wbm_dat_o <= '0;
                                after_gap <= RD_Y;
                            end
                            RD_Y: begin
                                y_reg     <= wbm_dat_i;
                                wbm_we_o  <= 1'b1;
                                wbm_adr_o <= dst_r + {14'd0, idx, 2'b00};
                                wbm_dat_o <= wbm_dat_i;
                                after_gap <= WR_Y;
                            end
                            default: begin
                                sample_cnt <= sample_cnt + 16'd1;
                                idx        <= idx_next;
                                wbm_we_o   <= 1'b0;
                                wbm_adr_o  <= src_r + {14'd0, idx_next, 2'b00};
                                wbm_dat_o  <= '0;
                                after_gap  <= RD_X;
                                if (idx_next == len_r) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end
                        endcase
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        wbm_cyc_o <= 1'b0;
                        err       <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    wbm_cyc_o <= 1'b1;
                    to_cnt    <= '0;
                    state     <= after_gap;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_fir_stream_dma.sv
// Bench for wb_fir_stream_dma: memory + FIR (Y = 2X+1) slave model, transaction
// scoreboard and per-cycle bus protocol checks, plus directed scenarios.
module tb_wb_fir_stream_dma;
    localparam logic [31:0] FIR_BASE = 32'h3000_0000;
    localparam logic [31:0] FIR_IN   = 32'h3000_0040;
    localparam logic [31:0] FIR_OUT  = 32'h3000_0044;
    localparam int          TIMEOUT  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_base = '0, dst_base = '0;
    logic [15:0] len = '0;
    logic        busy, done, err;
    logic [15:0] sample_cnt;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] dat_i = '0;
    logic        ack = 1'b0;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {we, adr, write data (0 for reads)}
    logic [64:0] exp_q[$];
    logic [31:0] fir_q[$];
    logic [31:0] mem[logic [31:0]];

    bit          never_ack_in = 0;
    int          y_delay = 0;
    int          wait_cnt = 0;
    int          txn_cnt = 0;
    int          win_cnt = 0;
    int          cyc_cycles = 0;
    int          busy_cycles = 0;
    logic [31:0] watch_adr = '0;

    logic        prev_cyc = 0, prev_ack = 0, prev_we = 0, prev_done = 0;
    logic [31:0] prev_adr = '0, prev_dat = '0;

    wb_fir_stream_dma #(.FIR_BASE(FIR_BASE), .TIMEOUT(TIMEOUT)) dut (
        .axis_clk(clk), .axis_rst_n(rst_n), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done), .err(err), .sample_cnt(sample_cnt),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor, protocol checker and slave model, all evaluated mid-cycle.
    always @(negedge clk) begin
        logic        give;
        logic [64:0] got;
        ack = 1'b0;
        dat_i = '0;
        if (!rst_n) begin
            exp_q.delete();
            fir_q.delete();
            wait_cnt = 0;
            prev_cyc = 0; prev_ack = 0; prev_done = 0;
        end else begin
            chk("stb_eq_cyc", stb, cyc);
            chk("sel", sel, cyc ? 4'hF : 4'h0);
            if (prev_ack) chk("gap_cyc_low", cyc, 1'b0);
            if (cyc && prev_cyc && !prev_ack)
                chk("bus_stable", {we, adr, dat_o}, {prev_we, prev_adr, prev_dat});
            if (done && prev_done) chk("done_one_cycle", 1'b0, 1'b1);
            if (done && busy) chk("busy_low_in_done", busy, 1'b0);
            if (cyc) cyc_cycles++;
            if (busy) busy_cycles++;
            if (cyc && adr == watch_adr) win_cnt++;
            if (cyc) begin
                give = 1'b1;
                if (we && adr == FIR_IN) give = !never_ack_in;
                else if (!we && adr == FIR_OUT) give = (fir_q.size() > 0) && (wait_cnt >= y_delay);
                if (give) begin
                    if (we) begin
                        if (adr == FIR_IN) fir_q.push_back(dat_o);
                        else mem[adr] = dat_o;
                    end else if (adr == FIR_OUT) begin
                        dat_i = 2 * fir_q.pop_front() + 1;
                    end else begin
                        dat_i = mem.exists(adr) ? mem[adr] : 32'd0;
                    end
                    got = {we, adr, we ? dat_o : 32'd0};
                    if (exp_q.size() == 0) chk("unexpected_txn", got, 65'd0);
                    else chk("txn", got, exp_q.pop_front());
                    txn_cnt++;
                    ack = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            prev_cyc = cyc; prev_ack = ack; prev_we = we;
            prev_adr = adr; prev_dat = dat_o; prev_done = done;
        end
    end

    // Expected bus traffic of a full block, from the source values the bench placed.
    task automatic expect_block(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] x;
            x = mem.exists(s + 4 * i) ? mem[s + 4 * i] : 32'd0;
            exp_q.push_back({1'b0, s + 32'(4 * i), 32'd0});
            exp_q.push_back({1'b1, FIR_IN, x});
            exp_q.push_back({1'b0, FIR_OUT, 32'd0});
            exp_q.push_back({1'b1, d + 32'(4 * i), 2 * x + 32'd1});
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src_base = s; dst_base = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, done, 1'b1);
    endtask

    initial begin
        mem[32'h3800_0000] = 32'd1;
        mem[32'h3800_0004] = 32'd2;
        mem[32'h3800_0008] = 32'd3;
        mem[32'h3800_0200] = 32'd10;

        repeat (3) @(negedge clk);
        chk("rst_cyc", {cyc, stb, we, sel}, 7'd0);
        chk("rst_adr_dat", {adr, dat_o}, 64'd0);
        chk("rst_status", {busy, done, err, sample_cnt}, 19'd0);
        rst_n = 1'b1;

        // Basic three-sample block
        txn_cnt = 0;
        expect_block(32'h3800_0000, 32'h3800_0100, 3);
        pulse_start(32'h3800_0000, 32'h3800_0100, 16'd3);
        chk("t1_busy_after_start", busy, 1'b1);
        chk("t1_first_bus", {cyc, we, adr}, {1'b1, 1'b0, 32'h3800_0000});
        wait_done(200, "t1_done");
        chk("t1_busy_in_done", busy, 1'b0);
        chk("t1_sample_cnt", sample_cnt, 16'd3);
        chk("t1_err", err, 1'b0);
        chk("t1_y0", mem[32'h3800_0100], 32'd3);
        chk("t1_y1", mem[32'h3800_0104], 32'd5);
        chk("t1_y2", mem[32'h3800_0108], 32'd7);
        chk("t1_txn_count", txn_cnt, 12);
        chk("t1_exp_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("t1_done_cleared", done, 1'b0);

        // Zero-length block
        cyc_cycles = 0; busy_cycles = 0;
        pulse_start(32'h3800_0000, 32'h3800_0600, 16'd0);
        chk("t2_done_next_cycle", done, 1'b1);
        @(negedge clk);
        chk("t2_done_one_cycle", done, 1'b0);
        repeat (3) @(negedge clk);
        chk("t2_no_cyc", cyc_cycles, 0);
        chk("t2_no_busy", busy_cycles, 0);

        // Late stream-out ack
        y_delay = 50; watch_adr = FIR_OUT; win_cnt = 0;
        expect_block(32'h3800_0008, 32'h3800_0700, 1);
        pulse_start(32'h3800_0008, 32'h3800_0700, 16'd1);
        wait_done(300, "t3_done");
        chk("t3_rdy_cycles", win_cnt, 51);
        chk("t3_y", mem[32'h3800_0700], 32'd7);
        chk("t3_err", err, 1'b0);
        chk("t3_sample_cnt", sample_cnt, 16'd1);
        y_delay = 0;

        // Stream-in never acks: timeout
        never_ack_in = 1; watch_adr = FIR_IN; win_cnt = 0;
        exp_q.push_back({1'b0, 32'h3800_0000, 32'd0});
        pulse_start(32'h3800_0000, 32'h3800_0800, 16'd2);
        wait_done(300, "t4_done");
        chk("t4_wrx_cycles", win_cnt, TIMEOUT);
        chk("t4_cyc_dropped", cyc, 1'b0);
        chk("t4_err", err, 1'b1);
        chk("t4_sample_cnt", sample_cnt, 16'd0);
        chk("t4_exp_drained", exp_q.size(), 0);
        never_ack_in = 0;
        @(negedge clk);
        chk("t4_err_sticky", err, 1'b1);
        expect_block(32'h3800_0200, 32'h3800_0300, 1);
        pulse_start(32'h3800_0200, 32'h3800_0300, 16'd1);
        chk("t4_err_cleared", err, 1'b0);
        wait_done(200, "t4b_done");
        chk("t4b_y", mem[32'h3800_0300], 32'd21);
        chk("t4b_err", err, 1'b0);

        // Start pulsed mid-block is ignored
        txn_cnt = 0;
        expect_block(32'h3800_0000, 32'h3800_0500, 2);
        pulse_start(32'h3800_0000, 32'h3800_0500, 16'd2);
        repeat (5) @(negedge clk);
        pulse_start(32'h3800_0200, 32'h3800_0900, 16'd5);
        wait_done(200, "t5_done");
        chk("t5_sample_cnt", sample_cnt, 16'd2);
        chk("t5_y0", mem[32'h3800_0500], 32'd3);
        chk("t5_y1", mem[32'h3800_0504], 32'd5);
        chk("t5_txn_count", txn_cnt, 8);
        chk("t5_no_stray_write", mem.exists(32'h3800_0900), 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_idle_after", {busy, cyc}, 2'b00);

        // Reset during RD_Y of the second sample
        y_delay = 30;
        expect_block(32'h3800_0000, 32'h3800_0A00, 2);
        pulse_start(32'h3800_0000, 32'h3800_0A00, 16'd2);
        begin
            int n = 0;
            while (!(cyc && adr == FIR_OUT && sample_cnt == 16'd1) && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("t6_reached_rdy2", {cyc, adr, sample_cnt}, {1'b1, FIR_OUT, 16'd1});
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_bus", {cyc, stb, we, sel}, 7'd0);
        chk("t6_rst_adr_dat", {adr, dat_o}, 64'd0);
        chk("t6_rst_status", {busy, done, err, sample_cnt}, 19'd0);
        rst_n = 1'b1;
        y_delay = 0;
        repeat (2) @(negedge clk);
        chk("t6_no_done_after_abort", done, 1'b0);
        expect_block(32'h3800_0004, 32'h3800_0B00, 1);
        pulse_start(32'h3800_0004, 32'h3800_0B00, 16'd1);
        wait_done(200, "t6_done");
        chk("t6_y", mem[32'h3800_0B00], 32'd5);
        chk("t6_sample_cnt", sample_cnt, 16'd1);
        chk("t6_err", err, 1'b0);
        chk("t6_no_write_abandoned", mem.exists(32'h3800_0A04), 1'b0);
        chk("t6_exp_drained", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
